// File: rtl/mov_unit_pkg.sv
// mov_unit_pkg: shared constants for the move/extend unit.
// Mode encodings, FSM state encoding and latency limits.
package mov_unit_pkg;

  localparam int MODE_W  = 3;
  localparam int LAT_MAX = 4;
  localparam int CNT_W   = $clog2(LAT_MAX);

  localparam logic [MODE_W-1:0] MODE_MOV   = 3'd0;
  localparam logic [MODE_W-1:0] MODE_MOVZB = 3'd1;
  localparam logic [MODE_W-1:0] MODE_MOVSB = 3'd2;
  localparam logic [MODE_W-1:0] MODE_MOVZH = 3'd3;
  localparam logic [MODE_W-1:0] MODE_MOVSH = 3'd4;
  localparam logic [MODE_W-1:0] MODE_MOVHI = 3'd5;
  localparam logic [MODE_W-1:0] MODE_CMOV  = 3'd6;
  localparam logic [MODE_W-1:0] MODE_RSVD  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mov_unit_if.sv
// mov_unit_if: request/response bundle between the control FSM (master)
// and the move unit (slave).
interface mov_unit_if
  import mov_unit_pkg::*;
#(parameter int WIDTH = 32);
  logic              start;
  logic [MODE_W-1:0] mode;
  logic [WIDTH-1:0]  src;
  logic [WIDTH-1:0]  dst_old;
  logic              cond;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  result;
  logic              wr_en;
  logic              err;

  modport master (output start, mode, src, dst_old, cond,
                  input  busy, done, result, wr_en, err);
  modport slave  (input  start, mode, src, dst_old, cond,
                  output busy, done, result, wr_en, err);
endinterface

// File: rtl/mov_unit_ext.sv
// mov_unit_ext: combinational mode decode and extend/select datapath.
// MOV_UNIT_CMOV_EN enables mode 6 (conditional move); otherwise mode 6
// is treated as reserved and the dst_old/cond inputs do not exist here.
module mov_unit_ext
  import mov_unit_pkg::*;
#(parameter int WIDTH = 32)
(
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  src,
`ifdef MOV_UNIT_CMOV_EN
  input  logic [WIDTH-1:0]  dst_old,
  input  logic              cond,
`endif
  output logic [WIDTH-1:0]  res,
  output logic              wr_en,
  output logic              err
);
  localparam int H = WIDTH / 2;

  // Select the next result; an illegal mode raises err and drops wr_en.
  always_comb begin
    res   = '0;
    wr_en = 1'b1;
    err   = 1'b0;
    case (mode)
      MODE_MOV:   res = src;
      MODE_MOVZB: res[7:0] = src[7:0];
      MODE_MOVSB: begin
        res      = {WIDTH{src[7]}};
        res[7:0] = src[7:0];
      end
      MODE_MOVZH: res[15:0] = src[15:0];
      MODE_MOVSH: begin
        res       = {WIDTH{src[15]}};
        res[15:0] = src[15:0];
      end
      MODE_MOVHI: res[WIDTH-1:H] = src[H-1:0];
`ifdef MOV_UNIT_CMOV_EN
      MODE_CMOV: begin
        res   = cond ? src : dst_old;
        wr_en = cond;
      end
`endif
      default: begin
        wr_en = 1'b0;
        err   = 1'b1;
      end
    endcase
  end
endmodule

// File: rtl/mov_unit.sv
// mov_unit: multicycle move/extend unit (IDLE -> EXEC x LATENCY -> DONE).
// Optional conditional move guarded by MOV_UNIT_CMOV_EN.
module mov_unit
  import mov_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1
)
(
  input  logic      clk,
  input  logic      rst,
  mov_unit_if.slave bus
);
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [MODE_W-1:0] mode_q;
  logic [WIDTH-1:0]  src_q;
`ifdef MOV_UNIT_CMOV_EN
  logic [WIDTH-1:0]  dst_q;
  logic              cond_q;
`endif
  logic [WIDTH-1:0]  res_q, ext_res;
  logic              wr_q, err_q, ext_wr, ext_err;
  logic              busy_c, done_c;
  logic              accept, fin;

  // A new request is taken in IDLE or DONE (back-to-back); EXEC ignores start.
  assign accept = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign fin    = (state_q == ST_EXEC) && (cnt_q == '0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and status outputs.
  always_comb begin
    state_d = state_q;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_EXEC;
      ST_EXEC: begin
        busy_c = 1'b1;
        if (cnt_q == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_c  = 1'b1;
        state_d = bus.start ? ST_EXEC : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture on accept so later input changes cannot disturb the op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= '0;
      src_q  <= '0;
`ifdef MOV_UNIT_CMOV_EN
      dst_q  <= '0;
      cond_q <= 1'b0;
`endif
    end else if (accept) begin
      mode_q <= bus.mode;
      src_q  <= bus.src;
`ifdef MOV_UNIT_CMOV_EN
      dst_q  <= bus.dst_old;
      cond_q <= bus.cond;
`endif
    end
  end

  // EXEC cycle counter: loaded with LATENCY-1, counts down to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   cnt_q <= '0;
    else if (accept)                           cnt_q <= CNT_W'(LATENCY - 1);
    else if (state_q == ST_EXEC && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end

  mov_unit_ext #(.WIDTH(WIDTH)) u_ext (
    .mode    (mode_q),
    .src     (src_q),
`ifdef MOV_UNIT_CMOV_EN
    .dst_old (dst_q),
    .cond    (cond_q),
`endif
    .res     (ext_res),
    .wr_en   (ext_wr),
    .err     (ext_err)
  );

  // Output registers: wr_en/err live for the DONE cycle only; result holds,
  // and an illegal mode leaves the previous result untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= '0;
      wr_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      wr_q  <= 1'b0;
      err_q <= 1'b0;
      if (fin) begin
        wr_q  <= ext_wr;
        err_q <= ext_err;
        if (!ext_err) res_q <= ext_res;
      end
    end
  end

  assign bus.busy   = busy_c;
  assign bus.done   = done_c;
  assign bus.result = res_q;
  assign bus.wr_en  = wr_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_mov_unit.sv
// tb_mov_unit: three units (LATENCY 1, 3, 4) driven from shared operands,
// checked against a transaction-level model of the move modes.
module tb_mov_unit;
  import mov_unit_pkg::*;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    st;
  logic [2:0]    mode;
  logic [W-1:0]  src, dst;
  logic          cond;
  logic          busy_o [3];
  logic          done_o [3];
  logic          wr_o   [3];
  logic          err_o  [3];
  logic [W-1:0]  res_o  [3];
  logic [W-1:0]  er     [3];
  int            n_tests = 0;
  int            n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    mov_unit_if #(.WIDTH(W)) bus ();
    mov_unit #(.WIDTH(W), .LATENCY(L)) dut (.clk(clk), .rst(rst), .bus(bus));
    assign bus.start   = st[g];
    assign bus.mode    = mode;
    assign bus.src     = src;
    assign bus.dst_old = dst;
    assign bus.cond    = cond;
    assign busy_o[g]   = bus.busy;
    assign done_o[g]   = bus.done;
    assign wr_o[g]     = bus.wr_en;
    assign err_o[g]    = bus.err;
    assign res_o[g]    = bus.result;
  end

  function automatic int lat(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 3 : 4);
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one completed operation.
  function automatic void model(input logic [2:0] m, input logic [W-1:0] s, input logic [W-1:0] d,
                                input logic c, input logic [W-1:0] prev,
                                output logic [W-1:0] r, output logic w, output logic e);
    r = prev; w = 1'b1; e = 1'b0;
    case (m)
      3'd0: r = s;
      3'd1: r = s % 256;
      3'd2: r = (s % 256) + (s[7] ? 32'hFFFFFF00 : 32'h0);
      3'd3: r = s % 65536;
      3'd4: r = (s % 65536) + (s[15] ? 32'hFFFF0000 : 32'h0);
      3'd5: r = (s % 65536) * 65536;
`ifdef MOV_UNIT_CMOV_EN
      3'd6: begin r = c ? s : d; w = c; end
`endif
      default: begin w = 1'b0; e = 1'b1; end
    endcase
  endfunction

  // Issue one op to all units and check the full busy/done/result timeline.
  task automatic run_op(input logic [2:0] m, input logic [W-1:0] s, input logic [W-1:0] d, input logic cnd);
    logic [W-1:0] nr [3];
    logic         nw [3];
    logic         ne [3];
    for (int g = 0; g < 3; g++) model(m, s, d, cnd, er[g], nr[g], nw[g], ne[g]);
    @(negedge clk);
    mode = m; src = s; dst = d; cond = cnd; st = 3'b111;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        st = 3'b000;
        mode = 3'($urandom); src = $urandom; dst = $urandom; cond = 1'($urandom);
      end
      for (int g = 0; g < 3; g++) begin
        int L;
        L = lat(g);
        chk($sformatf("busy m%0d L%0d c%0d", m, L, c), W'(busy_o[g]), W'(c <= L));
        chk($sformatf("done m%0d L%0d c%0d", m, L, c), W'(done_o[g]), W'(c == L + 1));
        chk($sformatf("wr_en m%0d L%0d c%0d", m, L, c), W'(wr_o[g]), W'((c == L + 1) && nw[g]));
        chk($sformatf("err m%0d L%0d c%0d", m, L, c), W'(err_o[g]), W'((c == L + 1) && ne[g]));
        chk($sformatf("result m%0d L%0d c%0d", m, L, c), res_o[g], (c >= L + 1) ? nr[g] : er[g]);
      end
    end
    for (int g = 0; g < 3; g++) er[g] = nr[g];
  endtask

  // Hold start high on one unit across DONE: second done follows LATENCY+1 later.
  task automatic b2b(input int g);
    logic [W-1:0] a, b;
    int n;
    a = $urandom; b = $urandom;
    @(negedge clk);
    mode = MODE_MOV; src = a; st[g] = 1'b1;
    @(negedge clk);
    src = b; n = 1;
    while (!done_o[g] && n < 12) begin @(negedge clk); n++; end
    chk($sformatf("b2b first L%0d", lat(g)), W'(n), W'(lat(g) + 1));
    chk($sformatf("b2b res1 L%0d", lat(g)), res_o[g], a);
    chk($sformatf("b2b wr1 L%0d", lat(g)), W'(wr_o[g]), W'(1));
    n = 0;
    do begin @(negedge clk); n++; end while (!done_o[g] && n < 12);
    st[g] = 1'b0;
    chk($sformatf("b2b gap L%0d", lat(g)), W'(n), W'(lat(g) + 1));
    chk($sformatf("b2b res2 L%0d", lat(g)), res_o[g], b);
    er[g] = b;
    repeat (2) @(negedge clk);
    chk($sformatf("b2b idle L%0d", lat(g)), W'(busy_o[g] | done_o[g]), W'(0));
  endtask

  task automatic chk_zero(input string tag);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("%s busy g%0d", tag, g), W'(busy_o[g]), '0);
      chk($sformatf("%s done g%0d", tag, g), W'(done_o[g]), '0);
      chk($sformatf("%s wr g%0d", tag, g), W'(wr_o[g]), '0);
      chk($sformatf("%s err g%0d", tag, g), W'(err_o[g]), '0);
      chk($sformatf("%s result g%0d", tag, g), res_o[g], '0);
    end
  endtask

  initial begin
    rst = 1'b1; st = '0; mode = '0; src = '0; dst = '0; cond = 1'b0;
    for (int g = 0; g < 3; g++) er[g] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); chk_zero("reset_idle"); end

    run_op(MODE_MOVSB, 32'h000000F0, 32'h0, 1'b0);
    run_op(MODE_MOVZB, 32'h000000F0, 32'h0, 1'b0);
    run_op(MODE_MOVHI, 32'h1234ABCD, 32'h0, 1'b0);
    run_op(MODE_CMOV,  32'd5, 32'd9, 1'b1);
    run_op(MODE_CMOV,  32'd5, 32'd9, 1'b0);
    run_op(MODE_RSVD,  32'hCAFEF00D, 32'h1, 1'b1);
    run_op(MODE_MOVSH, 32'h00008001, 32'h0, 1'b0);
    run_op(MODE_MOVZH, 32'hFFFF8001, 32'h0, 1'b0);
    run_op(MODE_MOVSH, 32'hFFFF7FFF, 32'h0, 1'b0);
    run_op(MODE_MOV,   32'h80000001, 32'h0, 1'b0);

    b2b(0); b2b(1); b2b(2);

    for (int i = 0; i < 40; i++)
      run_op(3'($urandom), $urandom, $urandom, 1'($urandom));

    // Reset in the middle of an operation aborts it with no done pulse.
    @(negedge clk);
    mode = MODE_MOV; src = 32'hDEADBEEF; st = 3'b111;
    @(negedge clk);
    st = 3'b000;
    @(negedge clk);
    rst = 1'b1;
    #1 chk_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); chk_zero("post_rst"); end
    for (int g = 0; g < 3; g++) er[g] = '0;
    run_op(MODE_MOV, 32'h13579BDF, 32'h0, 1'b0);
    run_op(MODE_MOVSB, 32'h00000080, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mov_unit.md
# mov_unit

Parametrised multicycle move/extend functional unit for the multicycle CPU execute stage, successor to the single-bit pass-through mover. Latches a source operand on a start strobe, applies one of several move modes (plain move, zero/sign extension, upper-half load, optional conditional move), and returns a registered result with a one-cycle done pulse and a register-file write enable. Sits beside the ALU; the control FSM issues start and waits for done.

## Interface
- WIDTH, 32, datapath width; even, at least 16.
- LATENCY, 1, number of EXEC cycles, 1 to 4.

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; sampled only when not busy.
- mode  in  3  move mode, sampled with start.
- src  in  WIDTH  source operand, sampled with start.
- dst_old  in  WIDTH  current destination value, sampled with start (CMOV not-taken path).
- cond  in  1  condition flag, sampled with start.
- busy  out  1  high while in EXEC.
- done  out  1  one-cycle completion pulse.
- result  out  WIDTH  registered result; held until the next completion.
- wr_en  out  1  destination write enable; valid only while done is high, 0 otherwise.
- err  out  1  illegal mode flag; valid only while done is high, 0 otherwise.

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE: start=1 latches mode/src/dst_old/cond, loads counter with LATENCY-1, goes to EXEC.
- EXEC: busy=1; counter decrements each cycle; at 0, result/wr_en/err are registered and the FSM goes to DONE.
- DONE: done=1 for exactly one cycle. start=1 in DONE is accepted (back-to-back) and goes to EXEC; otherwise goes to IDLE.
- start while in EXEC is ignored; no queuing.
- Modes, where H = WIDTH/2:
  - 0 MOV: src.
  - 1 MOVZB: zero-extend src[7:0].
  - 2 MOVSB: sign-extend src[7:0].
  - 3 MOVZH: zero-extend src[15:0].
  - 4 MOVSH: sign-extend src[15:0].
  - 5 MOVHI: src[H-1:0] shifted left by H, low half zero.
  - 6 CMOV: cond ? src : dst_old; wr_en=cond.
  - 7: reserved.
- wr_en=1 for modes 0-5.
- Reserved or disabled mode: err=1, wr_en=0, result keeps its previous value, and done still pulses.

## Timing
- Reset: state IDLE, counter 0, busy 0, done 0, result 0, wr_en 0, err 0.
- start sampled at edge k:
  - busy high from edge k+1 for LATENCY cycles.
  - done, result, wr_en and err are valid from edge k+1+LATENCY for one cycle.
  - result then holds.
- LATENCY=1: start at edge 0, busy in cycle 1, done in cycle 2.
- Back-to-back issue: start in the DONE cycle gives the next done LATENCY+1 cycles later, with no idle gap.
- Reset asserted mid-operation aborts immediately: no done pulse, outputs go to reset values.
- Operands may change after the start edge without affecting the in-flight result.

## Configuration
- MOV_UNIT_CMOV_EN defined: mode 6 performs the conditional move as above.
- Not defined: mode 6 is reserved (err=1, wr_en=0). The dst_old and cond ports remain present but are ignored, and their capture registers are removed.

## Structure
- Shared package mov_unit_pkg holds:
  - mode constants MODE_MOV through MODE_RSVD (3 bits);
  - state encoding ST_IDLE, ST_EXEC, ST_DONE;
  - the LATENCY upper limit constant (4).
- Sub-module mov_unit_ext: purely combinational mode decode and extend/select datapath, producing the next result, wr_en and err from the latched operands.
- mov_unit holds the FSM, counter, operand latches and output registers.

## Test plan
- Reset then idle: rst pulse with start=0 -> busy=0, done=0, result=0 for 10 cycles.
- MOVSB, WIDTH=32, LATENCY=1, src=0x000000F0 -> done at start+2, result=0xFFFFFFF0, wr_en=1, err=0. MOVZB with the same src -> 0x000000F0.
- MOVHI src=0x1234ABCD, LATENCY=3 -> busy for 3 cycles, done at start+4, result=0xABCD0000.
- CMOV with MOV_UNIT_CMOV_EN: src=5, dst_old=9:
  - cond=1 -> result=5, wr_en=1;
  - cond=0 -> result=9, wr_en=0.
  - Without the macro: err=1, wr_en=0, result unchanged.
- Back-to-back and overlap:
  - start held high across DONE -> second done exactly LATENCY+1 cycles after the first;
  - start pulses during EXEC are ignored.
  - Mode 7 -> err=1, wr_en=0.
- Reset mid-EXEC with LATENCY=4, rst at cycle 2 -> no done pulse, all outputs 0; a new start after reset completes normally.
